// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU/MDU: op encodings, FSM states, ALUOp codes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  // M-extension ops, encoded by their funct3 value.
  typedef enum logic [2:0] {
    M_MUL    = 3'b000, M_MULH = 3'b001, M_MULHSU = 3'b010, M_MULHU = 3'b011,
    M_DIV    = 3'b100, M_DIVU = 3'b101, M_REM    = 3'b110, M_REMU  = 3'b111
  } m_op_t;

  // EXEC holds a single-cycle op for one cycle so its result lands one edge after accept.
  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX, S_DONE
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // Base (non-M) op selection from ALUOp and the instruction funct fields.
  function automatic alu_op_t decode_funct(input logic [1:0] aluop, input logic opb5,
                                           input logic [2:0] f3, input logic f7b5);
    alu_op_t op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (f3)
          3'b000: op = (opb5 && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001: op = ALU_SLL;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b101: op = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Operation bus between the execute-stage controller (master) and alu_mdu_seq (slave).
// Handshake: an op transfers on a rising edge where in_valid && in_ready; the master
// holds its fields stable while in_valid is high and in_ready is low. out_valid is a
// one-cycle pulse with no back-pressure; result/zero/illegal stay valid until the next pulse.
interface alu_mdu_seq_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic            opb5;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (output in_valid, ALUOp, opb5, funct3, funct7b5, funct7b0, src_a, src_b,
                  input  in_ready, out_valid, result, zero, illegal);
  modport slave  (input  in_valid, ALUOp, opb5, funct3, funct7b5, funct7b0, src_a, src_b,
                  output in_ready, out_valid, result, zero, illegal);
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle for XLEN cycles; sign fix-up is combinational.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  m_op_t           op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);
  localparam int SHW = $clog2(XLEN);

  // Multiply: acc = {partial high, multiplier}, opnd = multiplicand.
  // Divide:   acc = {remainder, dividend/quotient}, opnd = divisor.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  m_op_t             op_q;
  logic              neg_a_q, neg_b_q, busy;
  logic [SHW-1:0]    cnt;

  logic              a_sgn, b_sgn, neg_a_d, neg_b_d;
  logic [XLEN-1:0]   mag_a_d, mag_b_d;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_f;
  logic [XLEN-1:0]   quo_f, rem_f;

  // Operand signedness and magnitudes at start, plus one iteration step of each algorithm.
  always_comb begin
    a_sgn    = op inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
    b_sgn    = op inside {M_MUL, M_MULH, M_DIV, M_REM};
    neg_a_d  = a_sgn && a[XLEN-1];
    neg_b_d  = b_sgn && b[XLEN-1];
    mag_a_d  = neg_a_d ? -a : a;
    mag_b_d  = neg_b_d ? -b : b;
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  assign last = busy && (cnt == SHW'(XLEN - 1));

  // Sign fix-up and half/quotient/remainder selection of the finished value.
  always_comb begin
    prod_f = (neg_a_q ^ neg_b_q) ? -acc : acc;
    quo_f  = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_f  = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      M_MUL:          result = prod_f[XLEN-1:0];
      M_DIV, M_DIVU:  result = quo_f;
      M_REM, M_REMU:  result = rem_f;
      default:        result = prod_f[2*XLEN-1:XLEN];
    endcase
  end

  // Operand capture on start, then one iteration per cycle until the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      opnd    <= '0;
      op_q    <= M_MUL;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      op_q    <= op;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      opnd    <= op[2] ? mag_b_d : mag_a_d;
      acc     <= {{XLEN{1'b0}}, (op[2] ? mag_a_d : mag_b_d)};
      busy    <= 1'b1;
      cnt     <= '0;
    end else if (busy) begin
      acc <= op_q[2] ? div_next : mul_next;
      cnt <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with optional iterative M-extension. Base ops, illegal ops and the
// divide-by-zero / signed-overflow short cuts finish in one cycle; MUL*/DIV*/REM* iterate.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  alu_mdu_seq_if.slave bus,
  output state_t       state_dbg
);
  localparam int SHW = $clog2(XLEN);

  state_t          state, state_n;
  logic            accept, load_res, mdu_start, mdu_last;
  logic            m_sel, div_zero, div_ovf, go_mul, go_div, short_ill, ill_d;
  logic [XLEN-1:0] short_res, res_d, mdu_result, pend_res;
  logic            pend_ill;
  alu_op_t         base_op;
  m_op_t           m_op;

  function automatic logic [XLEN-1:0] alu_exec(input alu_op_t op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $unsigned($signed(a) >>> sh);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  assign accept       = bus.in_valid && (state == S_IDLE);
  assign bus.in_ready = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign state_dbg    = state;

  // Decode the offered op into a one-cycle result or a multiply/divide launch.
  always_comb begin
    m_op      = m_op_t'(bus.funct3);
    m_sel     = (bus.ALUOp == ALUOP_FUNCT) && bus.opb5 && bus.funct7b0;
    base_op   = decode_funct(bus.ALUOp, bus.opb5, bus.funct3, bus.funct7b5);
    div_zero  = (bus.src_b == '0);
    div_ovf   = (m_op == M_DIV || m_op == M_REM) && (bus.src_b == '1) &&
                (bus.src_a == {1'b1, {(XLEN-1){1'b0}}});
    short_res = '0;
    short_ill = 1'b0;
    go_mul    = 1'b0;
    go_div    = 1'b0;
    if (bus.ALUOp == ALUOP_RSVD) begin
      short_ill = 1'b1;
    end else if (m_sel) begin
      if (!ENABLE_M)            short_ill = 1'b1;
      else if (!bus.funct3[2])  go_mul = 1'b1;
      else if (div_zero)        short_res = (m_op == M_DIV || m_op == M_DIVU) ? '1 : bus.src_a;
      else if (div_ovf)         short_res = (m_op == M_DIV) ? bus.src_a : '0;
      else                      go_div = 1'b1;
    end else begin
      short_res = alu_exec(base_op, bus.src_a, bus.src_b);
    end
  end

  // Next state and result-load control; flush overrides everything back to IDLE.
  always_comb begin
    state_n   = state;
    load_res  = 1'b0;
    res_d     = pend_res;
    ill_d     = pend_ill;
    mdu_start = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        mdu_start = go_mul || go_div;
        state_n   = go_mul ? S_MUL : (go_div ? S_DIV : S_EXEC);
      end
      S_EXEC: begin
        state_n  = S_DONE;
        load_res = 1'b1;
      end
      S_MUL, S_DIV: if (mdu_last) state_n = S_FIX;
      S_FIX: begin
        state_n  = S_DONE;
        load_res = 1'b1;
        res_d    = mdu_result;
        ill_d    = 1'b0;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n   = S_IDLE;
      load_res  = 1'b0;
      mdu_start = 1'b0;
    end
  end

  // State, pending one-cycle result, and the architecturally visible outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pend_res    <= '0;
      pend_ill    <= 1'b0;
      bus.result  <= '0;
      bus.zero    <= 1'b1;
      bus.illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !flush) begin
        pend_res <= short_res;
        pend_ill <= short_ill;
      end
      if (load_res) begin
        bus.result  <= res_d;
        bus.zero    <= (res_d == '0);
        bus.illegal <= ill_d;
      end
    end
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .abort  (flush),
    .start  (mdu_start),
    .op     (m_op),
    .a      (bus.src_a),
    .b      (bus.src_b),
    .last   (mdu_last),
    .result (mdu_result)
  );

endmodule
